// File: rtl/kb_stopwatch_ctrl_pkg.sv
// Shared definitions for the keyboard-to-stopwatch command sequencer:
// scan codes, run-state and command encodings, button indices and the
// small mapping helpers used by both the parser and the pulse engine.
package kb_cmd_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_START = 8'h1B;
  localparam logic [7:0] SC_PAUSE = 8'h4D;
  localparam logic [7:0] SC_CLEAR = 8'h2D;

  localparam int BTN_START = 0;
  localparam int BTN_PAUSE = 1;
  localparam int BTN_CLEAR = 2;

  typedef enum logic [1:0] {
    RS_STOPPED = 2'd0,
    RS_RUNNING = 2'd1,
    RS_PAUSED  = 2'd2
  } run_state_e;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_PAUSE = 2'd1,
    CMD_CLEAR = 2'd2
  } cmd_e;

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_EXT   = 2'd1,
    P_BREAK = 2'd2
  } parse_e;

  typedef enum logic [1:0] {
    E_IDLE  = 2'd0,
    E_PULSE = 2'd1,
    E_GAP   = 2'd2
  } engine_e;

  // True when the byte is one of the three command make codes.
  function automatic logic is_cmd_key(input logic [7:0] k);
    return (k == SC_START) || (k == SC_PAUSE) || (k == SC_CLEAR);
  endfunction

  // Command encoded by a make code; only meaningful when is_cmd_key(k).
  function automatic cmd_e key_to_cmd(input logic [7:0] k);
    case (k)
      SC_PAUSE: return CMD_PAUSE;
      SC_CLEAR: return CMD_CLEAR;
      default:  return CMD_START;
    endcase
  endfunction

  // One-hot button pattern driven while a command's pulse is active.
  function automatic logic [3:0] cmd_to_btn(input cmd_e c);
    case (c)
      CMD_START: return 4'b0001 << BTN_START;
      CMD_PAUSE: return 4'b0001 << BTN_PAUSE;
      CMD_CLEAR: return 4'b0001 << BTN_CLEAR;
      default:   return 4'b0000;
    endcase
  endfunction

  // Stopwatch state reached once a command has been issued.
  function automatic run_state_e cmd_target(input cmd_e c);
    case (c)
      CMD_START: return RS_RUNNING;
      CMD_PAUSE: return RS_PAUSED;
      default:   return RS_STOPPED;
    endcase
  endfunction

endpackage

// File: rtl/kb_stopwatch_ctrl_if.sv
// Bus between the PS/2 decoder side and the stopwatch button side.
// master: the decoder/environment; slave: kb_stopwatch_ctrl.
interface kb_stopwatch_ctrl_if;
  logic       key_ready;
  logic [7:0] key;
  logic [3:0] btn;
  logic [1:0] run_state;
  logic       cmd_drop;
  logic       cmd_reject;

  modport master (output key_ready, output key,
                  input  btn, input run_state, input cmd_drop, input cmd_reject);
  modport slave  (input  key_ready, input key,
                  output btn, output run_state, output cmd_drop, output cmd_reject);
endinterface

// File: rtl/kb_stopwatch_ctrl_btn_pulse_gen.sv
// Button pulse engine: issues one fixed-width one-hot pulse per command,
// enforces a minimum low gap between pulses and holds one pending command.
// A clear always replaces the pending entry; other commands are dropped
// when the entry is already occupied.
module btn_pulse_gen
  import kb_cmd_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid_i,
  input  cmd_e       cmd_i,
  output logic [3:0] btn_o,
  output logic       start_o,
  output cmd_e       start_cmd_o,
  output logic       drop_o,
  output logic       pend_valid_o,
  output cmd_e       pend_cmd_o
);

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  engine_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cmd_e          cur_q, cur_d;
  logic          pend_valid_q, pend_valid_d;
  cmd_e          pend_cmd_q, pend_cmd_d;
  logic [3:0]    btn_q, btn_d;
  logic          launch_s, consume_s, direct_s, drop_s;
  cmd_e          launch_cmd_s;

  // State, counter, pending entry and registered button outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= E_IDLE;
      cnt_q        <= '0;
      cur_q        <= CMD_START;
      pend_valid_q <= 1'b0;
      pend_cmd_q   <= CMD_START;
      btn_q        <= 4'b0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      pend_valid_q <= pend_valid_d;
      pend_cmd_q   <= pend_cmd_d;
      btn_q        <= btn_d;
    end
  end

  // Next-state: pulse/gap sequencing, launch selection and pending buffer update.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_d        = cur_q;
    pend_valid_d = pend_valid_q;
    pend_cmd_d   = pend_cmd_q;
    launch_s     = 1'b0;
    launch_cmd_s = cur_q;
    consume_s    = 1'b0;
    drop_s       = 1'b0;
    // Only an idle engine with nothing queued lets a command straight through.
    direct_s     = cmd_valid_i && (state_q == E_IDLE) && !pend_valid_q;

    case (state_q)
      E_IDLE: begin
        if (pend_valid_q) begin
          launch_s     = 1'b1;
          launch_cmd_s = pend_cmd_q;
          consume_s    = 1'b1;
        end else if (cmd_valid_i) begin
          launch_s     = 1'b1;
          launch_cmd_s = cmd_i;
        end else begin
          state_d = E_IDLE;
        end
      end
      E_PULSE: begin
        if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
          state_d = E_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      E_GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          if (pend_valid_q) begin
            launch_s     = 1'b1;
            launch_cmd_s = pend_cmd_q;
            consume_s    = 1'b1;
          end else begin
            state_d = E_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = E_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (launch_s) begin
      state_d = E_PULSE;
      cnt_d   = '0;
      cur_d   = launch_cmd_s;
    end else begin
      cur_d = cur_q;
    end

    if (consume_s) begin
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end

    // A slot being emptied this cycle counts as free for a new arrival.
    if (cmd_valid_i && !direct_s) begin
      if (!pend_valid_q || consume_s || (cmd_i == CMD_CLEAR)) begin
        pend_valid_d = 1'b1;
        pend_cmd_d   = cmd_i;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      drop_s = 1'b0;
    end

    if (state_d == E_PULSE) begin
      btn_d = cmd_to_btn(cur_d);
    end else begin
      btn_d = 4'b0000;
    end
  end

  assign btn_o        = btn_q;
  assign start_o      = launch_s;
  assign start_cmd_o  = launch_cmd_s;
  assign drop_o       = drop_s;
  assign pend_valid_o = pend_valid_q;
  assign pend_cmd_o   = pend_cmd_q;

endmodule

// File: rtl/kb_stopwatch_ctrl.sv
// Keyboard-to-stopwatch command sequencer top. Parses PS/2 bytes (prefix and
// break codes stripped), checks each command against the run state projected
// through the pending command, and hands legal ones to btn_pulse_gen.
// Optional feature macro: KB_TYPEMATIC_FILTER_EN (ignore repeated make codes
// of a key until its break sequence is seen).
module kb_stopwatch_ctrl
  import kb_cmd_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                clk,
  input  logic                reset,
  kb_stopwatch_ctrl_if.slave  bus
);

  parse_e     pstate_q, pstate_d;
  run_state_e run_state_q, run_state_d;
  run_state_e proj_s;
  logic       drop_q, reject_q;
  logic       cmd_hit_s, held_s, legal_s, accept_s, reject_s;
  cmd_e       cmd_s;
  logic [3:0] btn_s;
  logic       start_s, drop_s, pend_valid_s;
  cmd_e       start_cmd_s, pend_cmd_s;

  // Parser state, run state and one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pstate_q    <= P_IDLE;
      run_state_q <= RS_STOPPED;
      drop_q      <= 1'b0;
      reject_q    <= 1'b0;
    end else begin
      pstate_q    <= pstate_d;
      run_state_q <= run_state_d;
      drop_q      <= drop_s;
      reject_q    <= reject_s;
    end
  end

  // Parser next state and make-code command decode.
  always_comb begin
    pstate_d  = pstate_q;
    cmd_hit_s = 1'b0;
    cmd_s     = key_to_cmd(bus.key);
    if (bus.key_ready) begin
      case (pstate_q)
        P_IDLE: begin
          if (bus.key == SC_BREAK) begin
            pstate_d = P_BREAK;
          end else if (bus.key == SC_EXT) begin
            pstate_d = P_EXT;
          end else begin
            cmd_hit_s = is_cmd_key(bus.key);
          end
        end
        P_EXT: begin
          if (bus.key == SC_BREAK) begin
            pstate_d = P_BREAK;
          end else begin
            pstate_d = P_IDLE;
          end
        end
        P_BREAK: pstate_d = P_IDLE;
        default: pstate_d = P_IDLE;
      endcase
    end else begin
      pstate_d = pstate_q;
    end
  end

`ifdef KB_TYPEMATIC_FILTER_EN
  logic [3:0] held_q, held_d;
  logic       brk_hit_s;

  // Held flags: set by an accepted make code, cleared by that key's break byte.
  always_comb begin
    held_d    = held_q;
    brk_hit_s = bus.key_ready && (pstate_q == P_BREAK) && is_cmd_key(bus.key);
    if (accept_s) begin
      held_d[cmd_s] = 1'b1;
    end else if (brk_hit_s) begin
      held_d[key_to_cmd(bus.key)] = 1'b0;
    end else begin
      held_d = held_q;
    end
  end

  // Held-flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q <= 4'b0000;
    end else begin
      held_q <= held_d;
    end
  end

  assign held_s = held_q[cmd_s];
`else
  assign held_s = 1'b0;
`endif

  // Legality against the state the stopwatch will reach once the pending
  // command issues, plus the run-state update when a pulse begins.
  always_comb begin
    if (pend_valid_s) begin
      proj_s = cmd_target(pend_cmd_s);
    end else begin
      proj_s = run_state_q;
    end
    case (cmd_s)
      CMD_START: legal_s = (proj_s != RS_RUNNING);
      CMD_PAUSE: legal_s = (proj_s == RS_RUNNING);
      CMD_CLEAR: legal_s = 1'b1;
      default:   legal_s = 1'b0;
    endcase
    accept_s = cmd_hit_s && !held_s && legal_s;
    reject_s = cmd_hit_s && !held_s && !legal_s;
    if (start_s) begin
      run_state_d = cmd_target(start_cmd_s);
    end else begin
      run_state_d = run_state_q;
    end
  end

  btn_pulse_gen #(
    .PULSE_CYCLES (PULSE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_pulse (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid_i  (accept_s),
    .cmd_i        (cmd_s),
    .btn_o        (btn_s),
    .start_o      (start_s),
    .start_cmd_o  (start_cmd_s),
    .drop_o       (drop_s),
    .pend_valid_o (pend_valid_s),
    .pend_cmd_o   (pend_cmd_s)
  );

  assign bus.btn        = btn_s;
  assign bus.run_state  = run_state_q;
  assign bus.cmd_drop   = drop_q;
  assign bus.cmd_reject = reject_q;

endmodule

// File: tb/tb_kb_stopwatch_ctrl.sv
// Directed bench for kb_stopwatch_ctrl: expected button pulses are queued when
// keys are sent; a negedge monitor records each completed pulse (pattern,
// run state at its first cycle, width, preceding low gap) for comparison.
module tb_kb_stopwatch_ctrl;
  import kb_cmd_pkg::*;

  localparam int PULSE = 4;
  localparam int GAP   = 2;
`ifdef KB_TYPEMATIC_FILTER_EN
  localparam logic [31:0] EXP_REPEAT_REJ = 32'd0;
  localparam logic [31:0] EXP_REJECTS    = 32'd1;
  localparam logic [31:0] EXP_DROPS      = 32'd0;
`else
  localparam logic [31:0] EXP_REPEAT_REJ = 32'd1;
  localparam logic [31:0] EXP_REJECTS    = 32'd2;
  localparam logic [31:0] EXP_DROPS      = 32'd1;
`endif

  typedef struct {
    logic [3:0] btn;
    logic [1:0] rs;
    int         width;
    int         gap;
  } pulse_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  pulse_t obs_q[$];
  pulse_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int obs_rd = 0;

  logic [3:0] prev_btn, start_btn;
  logic [1:0] start_rs;
  int width_r, low_r, gap_r, reject_cnt, drop_cnt;

  kb_stopwatch_ctrl_if ifc();

  kb_stopwatch_ctrl #(.PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // Pulse and status-event monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_btn <= 4'b0000;
      width_r  <= 0;
      low_r    <= 99;
    end else begin
      prev_btn <= ifc.btn;
      if (ifc.btn != 4'b0000) begin
        if (prev_btn == 4'b0000) begin
          start_btn <= ifc.btn;
          start_rs  <= ifc.run_state;
          gap_r     <= low_r;
          width_r   <= 1;
        end else begin
          width_r <= width_r + 1;
        end
      end else begin
        if (prev_btn != 4'b0000) begin
          obs_q.push_back('{start_btn, start_rs, width_r, gap_r});
          low_r <= 1;
        end else begin
          low_r <= low_r + 1;
        end
      end
      if (ifc.cmd_reject) reject_cnt <= reject_cnt + 1;
      if (ifc.cmd_drop)   drop_cnt   <= drop_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic expect_pulse(input logic [3:0] b, input logic [1:0] rs, input int gap);
    exp_q.push_back('{b, rs, PULSE, gap});
  endtask

  task automatic drain(input string tag);
    pulse_t e;
    pulse_t o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin
        o = obs_q[obs_rd];
        obs_rd++;
        chk({tag, "_btn"},   32'(o.btn),   32'(e.btn));
        chk({tag, "_rs"},    32'(o.rs),    32'(e.rs));
        chk({tag, "_width"}, 32'(o.width), 32'(e.width));
        if (e.gap >= 0) chk({tag, "_gap"}, 32'(o.gap), 32'(e.gap));
      end else begin
        chk({tag, "_missing"}, 32'(obs_q.size()), 32'(obs_rd + 1));
      end
    end
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(obs_rd));
  endtask

  task automatic send(input logic [7:0] k);
    @(negedge clk);
    ifc.key       = k;
    ifc.key_ready = 1'b1;
    @(negedge clk);
    ifc.key_ready = 1'b0;
    ifc.key       = 8'h00;
  endtask

  task automatic release_key(input logic [7:0] k);
    send(SC_BREAK);
    send(k);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    ifc.key_ready = 1'b0;
    ifc.key       = 8'h00;
    reset_cnt_init();
    idle(3);
    chk("rst_btn",    32'(ifc.btn),        32'h0);
    chk("rst_rs",     32'(ifc.run_state),  32'(RS_STOPPED));
    chk("rst_drop",   32'(ifc.cmd_drop),   32'h0);
    chk("rst_reject", 32'(ifc.cmd_reject), 32'h0);
    reset = 1'b0;
    idle(2);

    // Single start: pulse begins the cycle after the strobe.
    expect_pulse(4'b0001, RS_RUNNING, -1);
    send(SC_START);
    chk("t1_btn_first", 32'(ifc.btn),       32'h1);
    chk("t1_rs_first",  32'(ifc.run_state), 32'(RS_RUNNING));
    idle(16);
    release_key(SC_START);
    expect_pulse(4'b0100, RS_STOPPED, -1);
    send(SC_CLEAR);
    idle(16);
    release_key(SC_CLEAR);
    drain("t1");

    // Start, pause (buffered), clear (replaces pending pause).
    expect_pulse(4'b0001, RS_RUNNING, -1);
    expect_pulse(4'b0100, RS_STOPPED, GAP);
    send(SC_START);
    send(SC_PAUSE);
    send(SC_CLEAR);
    idle(20);
    chk("t2_rs_final", 32'(ifc.run_state), 32'(RS_STOPPED));
    chk("t2_no_drop",  32'(drop_cnt),      32'h0);
    release_key(SC_START);
    release_key(SC_PAUSE);
    release_key(SC_CLEAR);
    drain("t2");

    // Pause while stopped is rejected for exactly one cycle.
    send(SC_PAUSE);
    chk("t3_reject_on", 32'(ifc.cmd_reject), 32'h1);
    chk("t3_btn",       32'(ifc.btn),        32'h0);
    idle(1);
    chk("t3_reject_off", 32'(ifc.cmd_reject), 32'h0);
    idle(8);
    release_key(SC_PAUSE);
    drain("t3");

    // Break and extended sequences never issue; parser returns to idle.
    send(SC_BREAK);
    send(SC_START);
    send(SC_EXT);
    send(SC_START);
    idle(10);
    chk("t4_no_pulse", 32'(obs_q.size()), 32'(obs_rd));
    chk("t4_rs",       32'(ifc.run_state), 32'(RS_STOPPED));
    expect_pulse(4'b0001, RS_RUNNING, -1);
    send(SC_START);
    chk("t4_btn_after", 32'(ifc.btn), 32'h1);
    idle(16);
    release_key(SC_START);
    drain("t4");

    // Typematic repeat of start while running.
    expect_pulse(4'b0100, RS_STOPPED, -1);
    send(SC_CLEAR);
    idle(16);
    release_key(SC_CLEAR);
    expect_pulse(4'b0001, RS_RUNNING, -1);
    send(SC_START);
    idle(16);
    send(SC_START);
    chk("t5_repeat_reject", 32'(ifc.cmd_reject), EXP_REPEAT_REJ);
    idle(16);
    chk("t5_rs", 32'(ifc.run_state), 32'(RS_RUNNING));
    drain("t5");

    // Reset in the second cycle of a pause pulse.
    send(SC_PAUSE);
    chk("t6_btn_on", 32'(ifc.btn),       32'h2);
    chk("t6_rs_on",  32'(ifc.run_state), 32'(RS_PAUSED));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_btn_rst", 32'(ifc.btn),       32'h0);
    chk("t6_rs_rst",  32'(ifc.run_state), 32'(RS_STOPPED));
    idle(2);
    reset = 1'b0;
    idle(12);
    chk("t6_btn_after", 32'(ifc.btn), 32'h0);
    chk("t6_no_pulse",  32'(obs_q.size()), 32'(obs_rd));

    // Drop: pending slot holds start when a second pause arrives.
    expect_pulse(4'b0001, RS_RUNNING, -1);
    send(SC_START);
    idle(16);
    release_key(SC_START);
    expect_pulse(4'b0010, RS_PAUSED, -1);
    expect_pulse(4'b0001, RS_RUNNING, GAP);
    send(SC_PAUSE);
    send(SC_START);
    send(SC_PAUSE);
    chk("t7_drop_on", 32'(ifc.cmd_drop), EXP_DROPS);
    idle(1);
    chk("t7_drop_off", 32'(ifc.cmd_drop), 32'h0);
    idle(20);
    chk("t7_rs", 32'(ifc.run_state), 32'(RS_RUNNING));
    drain("t7");

    chk("tot_rejects", 32'(reject_cnt), EXP_REJECTS);
    chk("tot_drops",   32'(drop_cnt),   EXP_DROPS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic reset_cnt_init();
    @(negedge clk);
  endtask

  initial begin
    reject_cnt = 0;
    drop_cnt   = 0;
  end

endmodule
